// File: rtl/pc_sequencer.sv
// Mini-MIPS fetch front end: owns the PC, runs one outstanding imem request at a
// time and holds each fetched word for decode until it is consumed or squashed.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic [31:0] epc,
  output logic        bad_addr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic        kill;
  logic        active;
  logic        misaligned;
  logic        take_exc;
  logic        take_mis;
  logic        take_redir;
  logic        ctl_event;
  logic [31:0] event_pc;
  logic [31:0] seq_pc;

  function automatic logic [31:0] next_seq(input logic [31:0] cur);
    return cur + 32'd4;
  endfunction

  always_comb begin
    active     = (state != IDLE);
    misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    take_exc   = active && exc_req;
    take_mis   = active && !exc_req && misaligned;
    take_redir = active && !exc_req && redirect_valid && !misaligned;
    ctl_event  = take_exc || take_mis || take_redir;
    event_pc   = (take_exc || take_mis) ? EXC_VECTOR : redirect_pc;
    seq_pc     = next_seq(pc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      kill        <= 1'b0;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      epc         <= 32'h0;
      bad_addr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        FETCH: begin
          if (ctl_event) begin
            pc          <= event_pc;
            instr_valid <= 1'b0;
            // An in-flight request cannot be withdrawn: either reissue on this
            // ack or mark the pending one to be thrown away when it returns.
            if (imem_ack) begin
              imem_addr <= event_pc;
              kill      <= 1'b0;
            end else begin
              kill      <= 1'b1;
            end
          end else if (imem_ack) begin
            if (kill) begin
              kill      <= 1'b0;
              imem_addr <= pc;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ctl_event) begin
            pc          <= event_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= event_pc;
            state       <= FETCH;
          end else if (!stall) begin
            pc          <= seq_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= seq_pc;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase

      if (take_exc) begin
        epc      <= pc;
        bad_addr <= 1'b0;
      end else if (take_mis) begin
        epc      <= redirect_pc;
        bad_addr <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Sequences the program counter and instruction fetch for the Mini-MIPS front end. Owns the PC register and its update policy: reset vector, sequential increment, branch/jump redirect, exception vectoring with EPC capture, and decode back-pressure. Drives a single-outstanding request/acknowledge handshake to instruction memory and presents one fetched instruction at a time to decode.

## Interface
- RESET_PC, 32'h00400000, PC value loaded by reset (text segment start)
- EXC_VECTOR, 32'h80000180, PC loaded on exception or misaligned redirect
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req high
- imem_ack  in  1  single-cycle acknowledge; imem_rdata valid same cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr holds a valid instruction for decode
- instr  out  32  held instruction word
- pc  out  32  address of the instruction being fetched or held
- stall  in  1  decode cannot accept instr this cycle
- redirect_valid  in  1  branch/jump taken; one-cycle pulse
- redirect_pc  in  32  redirect target
- exc_req  in  1  exception request; one-cycle pulse
- epc  out  32  captured exception PC
- bad_addr  out  1  last exception was a misaligned redirect (sticky until next exception entry)

## Operation
- All outputs registered. Reset values: state IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr_valid=0, instr=0, epc=0, bad_addr=0.
- States: IDLE, FETCH, HOLD.
- IDLE: entered only by reset; next edge -> FETCH, imem_req<=1, imem_addr<=pc.
- FETCH: imem_req high. On imem_ack with kill=0: instr<=imem_rdata, instr_valid<=1, imem_req<=0 -> HOLD. On imem_ack with kill=1: discard data, clear kill, imem_addr<=pc, imem_req stays 1, remain FETCH.
- HOLD: instr_valid high, instr stable. stall=0: consumed this cycle; pc<=pc+4 (mod 2^32, wraps 32'hFFFFFFFC -> 0), instr_valid<=0, imem_req<=1, imem_addr<=pc+4 -> FETCH. stall=1: hold everything.
- Control-event priority, evaluated every cycle in FETCH/HOLD (ignored in IDLE): exc_req > misaligned redirect > redirect > sequential.
- exc_req: epc<=pc, bad_addr<=0, pc<=EXC_VECTOR.
- redirect_valid with redirect_pc[1:0]!=0: treated as exception; epc<=redirect_pc, bad_addr<=1, pc<=EXC_VECTOR.
- redirect_valid aligned: pc<=redirect_pc.
- On any event: instr_valid<=0 regardless of stall. In HOLD -> FETCH, imem_req<=1, imem_addr<=new pc. In FETCH: if imem_ack same cycle, data discarded, imem_addr<=new pc, req stays 1; else kill<=1 (request cannot be withdrawn; imem_addr held until ack).
- Exactly one request outstanding at any time.

## Timing
- Reset release at edge E0: imem_req=1 after E0 (cycle 1), imem_addr=RESET_PC.
- Zero-wait memory (ack in the request's first cycle): instr_valid high the following cycle; with stall=0, next request the cycle after. Throughput 1 instruction / 2 cycles; each memory wait cycle adds 1.
- Event-to-new-request latency: 1 cycle from HOLD or from FETCH with coincident ack; otherwise first cycle after the outstanding ack.
- Asynchronous reset mid-fetch: all outputs to reset values immediately; any late imem_ack while in IDLE is ignored.

## Test plan
- Reset/sequential: release reset, ack every request with zero wait, stall=0 -> imem_addr 0x00400000, 0x00400004, 0x00400008; instr_valid pulses every 2nd cycle; pc matches.
- Stall: hold stall=1 for 3 cycles in HOLD -> instr, pc, instr_valid unchanged, imem_req=0; stall drop -> next request at pc+4.
- Redirect during wait: in FETCH of 0x00400004 with ack delayed 3 cycles, pulse redirect_pc=0x00400100 -> first ack discarded (no instr_valid), next request imem_addr=0x00400100.
- Exception vs redirect same cycle in HOLD at pc=0x00400010: exc_req=1 and redirect_valid=1 -> epc=0x00400010, bad_addr=0, next imem_addr=0x80000180.
- Misaligned redirect to 0x00400102 -> epc=0x00400102, bad_addr=1, next imem_addr=0x80000180.
- Wrap and reset mid-op: sequential from pc=0xFFFFFFFC -> next imem_addr 0x00000000; assert reset_n=0 with request outstanding -> imem_req=0, instr_valid=0, pc=0x00400000 immediately, late ack ignored.
